bitfifo128_ctrl: RTL and testbench

- Controller that turns the 128x1 dual-port distributed RAM with registered outputs into a 1-bit-wide ready/valid FIFO.
- Drives the RAM write port (we/addr/data) and read port (addr/load).
- Consumes the registered read output as the FIFO head.
- Sits directly upstream of and around the RAM instance; serial bit producers feed it and bit consumers drain it.

---
 rtl/bitfifo128_ctrl.sv | 97 +++++++++
 tb/tb_bitfifo128_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitfifo128_ctrl.sv
// 1-bit ready/valid FIFO controller around a 128x1 dual-port RAM with a registered read output.
// Optional synchronous flush input when BITFIFO_FLUSH_EN is defined.
module bitfifo128_ctrl #(
    parameter int unsigned AW        = 7,
    parameter int unsigned AFULL_TH  = 120,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef BITFIFO_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          wr_bit,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_bit,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic          ram_wd,
    output logic [AW-1:0] ram_ra,
    output logic          ram_ld,
    input  logic          ram_q,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] AFULL_C  = AFULL_TH[AW:0];
    localparam logic [AW:0] AEMPTY_C = AEMPTY_TH[AW:0];
    localparam logic [AW:0] DEPTH_C  = {1'b1, {AW{1'b0}}};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        hv;
    logic [AW:0] mem_cnt;
    logic        wr_fire;
    logic        pop;
    logic        ld;
    logic        flush_i;

`ifdef BITFIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign mem_cnt = wr_ptr - rd_ptr;
    assign full    = (mem_cnt == DEPTH_C);
    assign count   = mem_cnt + {{AW{1'b0}}, hv};
    assign empty   = (count == '0);

    assign almost_full  = (mem_cnt >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_ready = !full;
    assign rd_valid = hv;
    assign rd_bit   = ram_q;

    assign wr_fire = wr_valid & !full;
    assign pop     = hv & rd_ready;
    // Refill the head register whenever it is empty or being consumed this cycle.
    assign ld      = (mem_cnt != '0) & (!hv | pop);

    assign ram_we = wr_fire & !flush_i;
    assign ram_wa = wr_ptr[AW-1:0];
    assign ram_wd = wr_bit;
    assign ram_ld = ld & !flush_i;
    assign ram_ra = rd_ptr[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hv     <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            hv     <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ld) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                hv     <= 1'b1;
            end else if (pop) begin
                hv     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitfifo128_ctrl.sv
// Directed bench for bitfifo128_ctrl with a behavioural 128x1 registered-output RAM.
module tb_bitfifo128_ctrl;

    localparam int unsigned AW = 7;

    logic          clk;
    logic          rst_n;
`ifdef BITFIFO_FLUSH_EN
    logic          flush;
`endif
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_bit;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_bit;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic          ram_wd;
    logic [AW-1:0] ram_ra;
    logic          ram_ld;
    logic          ram_q;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    bitfifo128_ctrl #(.AW(AW), .AFULL_TH(120), .AEMPTY_TH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef BITFIFO_FLUSH_EN
        .flush        (flush),
`endif
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_bit       (wr_bit),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_bit       (rd_bit),
        .ram_we       (ram_we),
        .ram_wa       (ram_wa),
        .ram_wd       (ram_wd),
        .ram_ra       (ram_ra),
        .ram_ld       (ram_ld),
        .ram_q        (ram_q),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // Behavioural RAM: synchronous write, read output register loaded by ram_ld.
    logic mem [128];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        if (ram_ld) ram_q <= mem[ram_ra];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check("drain_valid", 32'(rd_valid), 32'd1);
            check("drain_bit", 32'(rd_bit), 32'(e));
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        check("drain_rd_valid0", 32'(rd_valid), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count0", 32'(count), 32'd0);
    endtask

    initial begin
        logic b;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_bit   = 1'b0;
        rd_ready = 1'b0;
        ram_q    = 1'b0;
`ifdef BITFIFO_FLUSH_EN
        flush    = 1'b0;
`endif
        #12;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Write 1,0,1: head appears two cycles after the first write.
        wr_valid = 1'b1; wr_bit = 1'b1; tick(); exp_q.push_back(1'b1);
        check("lat_n1_valid", 32'(rd_valid), 32'd0);
        wr_bit = 1'b0; tick(); exp_q.push_back(1'b0);
        check("lat_n2_valid", 32'(rd_valid), 32'd1);
        check("lat_n2_bit", 32'(rd_bit), 32'd1);
        wr_bit = 1'b1; tick(); exp_q.push_back(1'b1);
        wr_valid = 1'b0;
        check("three_count", 32'(count), 32'd3);
        check("three_empty", 32'(empty), 32'd0);
        drain(3);

        // Fill to 129 with rd_ready low; count tracks accepted writes one-for-one.
        for (int k = 1; k <= 129; k++) begin
            b = 1'((k ^ (k >> 2)) & 1);
            wr_valid = 1'b1; wr_bit = b; tick(); exp_q.push_back(b);
            if (k == 4)   check("ae_at4", 32'(almost_empty), 32'd1);
            if (k == 5)   check("ae_at5", 32'(almost_empty), 32'd0);
            if (k == 120) check("af_at120", 32'(almost_full), 32'd0);
            if (k == 121) check("af_at121", 32'(almost_full), 32'd1);
            if (k == 128) begin
                check("fill128_full", 32'(full), 32'd0);
                check("fill128_count", 32'(count), 32'd128);
            end
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd129);
        check("fill_wr_ready", 32'(wr_ready), 32'd0);
        wr_bit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("full_ram_we", 32'(ram_we), 32'd0);
            tick();
        end
        check("full_hold_count", 32'(count), 32'd129);

        // One pop while full, then exactly one write refills it.
        rd_ready = 1'b1; wr_bit = 1'b1; tick();
        rd_ready = 1'b0;
        void'(exp_q.pop_front());
        check("pop1_bit", 32'(rd_bit), 32'(exp_q[0]));
        check("pop1_wr_ready", 32'(wr_ready), 32'd1);
        check("pop1_full", 32'(full), 32'd0);
        check("pop1_count", 32'(count), 32'd128);
        tick(); exp_q.push_back(1'b1);
        wr_valid = 1'b0;
        check("refill_full", 32'(full), 32'd1);
        check("refill_count", 32'(count), 32'd129);
        drain(129);

        // Stream 300 alternating bits; head after edge k is bit k-2, no bubbles.
        rd_ready = 1'b1;
        for (int k = 1; k <= 302; k++) begin
            wr_valid = (k <= 300);
            wr_bit   = 1'((k - 1) & 1);
            tick();
            if (k >= 2 && k <= 301) begin
                check("stream_valid", 32'(rd_valid), 32'd1);
                check("stream_bit", 32'(rd_bit), 32'((k - 2) & 1));
            end
            if (k == 150) check("stream_count", 32'(count), 32'd2);
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        check("stream_end_valid", 32'(rd_valid), 32'd0);
        check("stream_end_empty", 32'(empty), 32'd1);

        // Asynchronous reset at count=50 clears outputs without a clock edge.
        for (int k = 0; k < 50; k++) begin
            wr_valid = 1'b1; wr_bit = 1'(k & 1); tick();
        end
        wr_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd50);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_valid", 32'(rd_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        #2 rst_n = 1'b1;
        tick();
        wr_valid = 1'b1;
        wr_bit = 1'b0; tick(); exp_q.push_back(1'b0);
        wr_bit = 1'b1; tick(); exp_q.push_back(1'b1);
        wr_bit = 1'b1; tick(); exp_q.push_back(1'b1);
        wr_valid = 1'b0;
        drain(3);

`ifdef BITFIFO_FLUSH_EN
        for (int k = 0; k < 10; k++) begin
            wr_valid = 1'b1; wr_bit = 1'(k & 1); tick();
        end
        check("pre_flush_count", 32'(count), 32'd10);
        flush = 1'b1; rd_ready = 1'b1;
        #1;
        check("flush_ram_we", 32'(ram_we), 32'd0);
        check("flush_ram_ld", 32'(ram_ld), 32'd0);
        tick();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_rd_valid", 32'(rd_valid), 32'd0);
        wr_valid = 1'b1;
        wr_bit = 1'b1; tick(); exp_q.push_back(1'b1);
        wr_bit = 1'b0; tick(); exp_q.push_back(1'b0);
        wr_valid = 1'b0;
        drain(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
